// File: rtl/emitter_uart_pkg.sv
// Shared types and constants for the emitter_uart transmit-only UART.
package emitter_uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;  // start + 8 data + stop
  localparam int BIT_IDX_W  = $clog2(FRAME_BITS);

  // Shifter state: IDLE holds the line high, SHIFT walks the ten frame bits.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shifter_state_e;

  // Clock cycles per bit, truncated.
  function automatic int div_of(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/emitter_uart_fifo.sv
// Synchronous TX byte queue with asynchronous active-low reset.
// Push and pop may occur in the same cycle; a push while full is admitted
// only when a pop happens in that same cycle. rdata shows the oldest entry.
module emitter_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("emitter_uart_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the cleared count marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/emitter_uart.sv
// emitter_uart: transmit-only 8N1 UART, LSB first, idle-high line.
// Optional build macro EMITTER_UART_FIFO_EN adds a FIFO_DEPTH-entry byte
// queue in front of the shifter; without it a byte is only accepted when the
// shifter can start it immediately (single holding register = the shifter).
//
// Handshake: a byte on i_data is accepted on a rising edge where
// i_valid & o_ready is 1. i_valid may be a one-cycle pulse and may be raised
// while o_ready is 0; such an offer is silently dropped. o_ready never
// depends on i_valid.
module emitter_uart
  import emitter_uart_pkg::*;
#(
  parameter int clk_freq_hz = 100_000_000,
  parameter int baud_rate   = 1_000_000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_uart_tx,
  output logic                 o_dbg_state
);

  localparam int DIV = div_of(clk_freq_hz, baud_rate);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("emitter_uart: clk_freq_hz/baud_rate must be at least 2");
  end

  // Depth is validated in both builds so a configuration stays legal
  // whichever way the queue macro is set.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth_check
    $error("emitter_uart: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  shifter_state_e       state;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [CW-1:0]        div_cnt;
  logic [DATA_BITS:0]   shreg;     // remaining data bits plus the stop bit
  logic                 tx_q;

  logic                 last_cycle;
  logic                 free;
  logic                 load;
  logic [DATA_BITS-1:0] load_data;

  // Final cycle of the stop bit: the shifter can start the next frame here,
  // which is what makes back-to-back frames contiguous.
  assign last_cycle = (state == SHIFT) &&
                      (bit_idx == BIT_IDX_W'(FRAME_BITS - 1)) &&
                      (div_cnt == '0);
  assign free = (state == IDLE) || last_cycle;

`ifdef EMITTER_UART_FIFO_EN
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bypass;
  logic [DATA_BITS-1:0] fifo_rdata;

  // An empty queue with a free shifter sends the offered byte straight to
  // the line, so the first byte starts with the same latency as the
  // queue-less build. Otherwise bytes queue and the shifter pops in order.
  assign fifo_pop  = free & ~fifo_empty;
  assign bypass    = free & fifo_empty & i_valid;
  assign o_ready   = ~fifo_full | fifo_pop;
  assign fifo_push = i_valid & o_ready & ~bypass;
  assign load      = fifo_pop | bypass;
  assign load_data = fifo_pop ? fifo_rdata : i_data;
  assign o_busy    = ~free | ~fifo_empty;

  emitter_uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_resetn),
    .push  (fifo_push),
    .wdata (i_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  assign o_ready   = free;
  assign load      = i_valid & free;
  assign load_data = i_data;
  assign o_busy    = ~free;
`endif

  assign o_uart_tx   = tx_q;
  assign o_dbg_state = (state == SHIFT);

  // Shifter FSM: load drives the start bit, then each bit is held DIV
  // cycles; the divisor reloads at every bit boundary so there is no drift.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state   <= IDLE;
      bit_idx <= '0;
      div_cnt <= '0;
      shreg   <= '1;
      tx_q    <= 1'b1;
    end else if (load) begin
      state   <= SHIFT;
      bit_idx <= '0;
      div_cnt <= CW'(DIV - 1);
      shreg   <= {1'b1, load_data};
      tx_q    <= 1'b0;
    end else if (state == SHIFT) begin
      if (div_cnt != '0) begin
        div_cnt <= div_cnt - 1'b1;
      end else if (bit_idx == BIT_IDX_W'(FRAME_BITS - 1)) begin
        state <= IDLE;
        tx_q  <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 1'b1;
        div_cnt <= CW'(DIV - 1);
        tx_q    <= shreg[0];
        shreg   <= {1'b1, shreg[DATA_BITS:1]};
      end
    end
  end

endmodule

// File: tb/tb_emitter_uart.sv
// Bench for emitter_uart at 10 MHz / 1 Mbaud (10 cycles per bit).
// Line expectations come from the 8N1 frame rule (start 0, data LSB first,
// stop 1, each bit DIV cycles); an independent line decoder feeds a
// scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_emitter_uart;

  localparam int CLK_HZ    = 10_000_000;
  localparam int BAUD      = 1_000_000;
  localparam int DIV       = CLK_HZ / BAUD;
  localparam int FRAME_CYC = 10 * DIV;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       busy;
  logic       tx;
  logic       dbg_state;

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_q[$];

  emitter_uart #(
    .clk_freq_hz (CLK_HZ),
    .baud_rate   (BAUD),
    .FIFO_DEPTH  (16)
  ) dut (
    .i_clk       (clk),
    .i_resetn    (rst_n),
    .i_data      (data),
    .i_valid     (valid),
    .o_ready     (ready),
    .o_busy      (busy),
    .o_uart_tx   (tx),
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // Line level k cycles into a frame (k = 1 .. FRAME_CYC).
  function automatic logic line_bit(input logic [7:0] b, input int k);
    int slot;
    slot = (k - 1) / DIV;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // ---------------- line decoder / scoreboard ----------------
  bit         mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
      if (mon_active) begin
        if (mon_cnt % DIV == DIV / 2) begin
          if (mon_cnt / DIV == 0) begin
            n_total++;
            if (tx !== 1'b0) $display("FAIL mon_start got=%b exp=0", tx);
            else n_pass++;
          end else if (mon_cnt / DIV == 9) begin
            n_total++;
            if (tx !== 1'b1) $display("FAIL mon_stop got=%b exp=1", tx);
            else n_pass++;
          end else begin
            mon_byte[mon_cnt/DIV-1] = tx;
          end
        end
        if (mon_cnt == FRAME_CYC - 1) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL mon_byte got=%02h exp=<none>", mon_byte);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (mon_byte !== e) $display("FAIL mon_byte got=%02h exp=%02h", mon_byte, e);
            else n_pass++;
          end
          mon_active = 1'b0;
        end
        mon_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits (bounded) for o_ready and offers b; returns at the accept cycle.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    while (ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (ready !== 1'b1) $display("FAIL send_wait ready=%b exp=1", ready);
    else n_pass++;
    data  = b;
    valid = 1'b1;
  endtask

  // Follows one no-queue frame cycle by cycle from its accept cycle.
  // inj_k: offer 0xA5 at that offset; chain: offer chain_b in the ready
  // cycle; abort_k: drop reset at that offset and end the frame there.
  task automatic check_frame(input logic [7:0] b, input int inj_k,
                             input bit chain, input logic [7:0] chain_b,
                             input int abort_k);
    logic exp_rdy;
    if (abort_k == 0) exp_q.push_back(b);
    for (int k = 1; k <= FRAME_CYC; k++) begin
      @(negedge clk);
      valid = 1'b0;
      if (abort_k != 0 && k == abort_k) begin
        rst_n = 1'b0;
        #1;
        n_total++;
        if (tx !== 1'b1) $display("FAIL abort_tx got=%b exp=1", tx); else n_pass++;
        n_total++;
        if (ready !== 1'b1) $display("FAIL abort_ready got=%b exp=1", ready); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
        return;
      end
      exp_rdy = (k == FRAME_CYC);
      n_total++;
      if (tx !== line_bit(b, k))
        $display("FAIL frame_tx byte=%02h k=%0d got=%b exp=%b", b, k, tx, line_bit(b, k));
      else n_pass++;
      n_total++;
      if (ready !== exp_rdy)
        $display("FAIL frame_ready byte=%02h k=%0d got=%b exp=%b", b, k, ready, exp_rdy);
      else n_pass++;
      n_total++;
      if (busy !== ~exp_rdy)
        $display("FAIL frame_busy byte=%02h k=%0d got=%b exp=%b", b, k, busy, ~exp_rdy);
      else n_pass++;
      if (k == inj_k) begin
        data  = 8'hA5;
        valid = 1'b1;
      end
      if (k == FRAME_CYC && chain) begin
        data  = chain_b;
        valid = 1'b1;
      end
    end
  endtask

  task automatic check_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      valid = 1'b0;
      n_total++;
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL idle i=%0d got tx/ready/busy=%b%b%b exp=110", i, tx, ready, busy);
      else n_pass++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (tx !== 1'b1) $display("FAIL reset_tx i=%0d got=%b exp=1", i, tx); else n_pass++;
      n_total++;
      if (ready !== 1'b1) $display("FAIL reset_ready i=%0d got=%b exp=1", i, ready); else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy i=%0d got=%b exp=0", i, busy); else n_pass++;
      n_total++;
      if (dbg_state !== 1'b0) $display("FAIL reset_state i=%0d got=%b exp=0", i, dbg_state); else n_pass++;
    end
    rst_n = 1'b1;
  endtask

`ifndef EMITTER_UART_FIFO_EN
  task automatic test_basic();
    logic [7:0] b;
    send_byte(8'h55);
    check_frame(8'h55, 0, 1'b0, 8'h00, 0);
    b = 8'($urandom_range(0, 255));
    send_byte(b);
    check_frame(b, 0, 1'b0, 8'h00, 0);
  endtask

  task automatic test_ignore_busy();
    send_byte(8'h55);
    check_frame(8'h55, 30, 1'b0, 8'h00, 0);
    check_idle(15);
  endtask

  task automatic test_back_to_back();
    send_byte(8'h00);
    check_frame(8'h00, 0, 1'b1, 8'hFF, 0);
    check_frame(8'hFF, 0, 1'b0, 8'h00, 0);
    check_idle(3);
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h00);
    check_frame(8'h00, 0, 1'b0, 8'h00, 45);
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL hold_reset got tx/ready/busy=%b%b%b exp=110", tx, ready, busy);
      else n_pass++;
    end
    rst_n = 1'b1;
    check_idle(2);
    send_byte(8'h3C);
    check_frame(8'h3C, 0, 1'b0, 8'h00, 0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] nb;
    bit         ch;
    b = 8'($urandom_range(0, 255));
    send_byte(b);
    for (int i = 0; i < 6; i++) begin
      nb = 8'($urandom_range(0, 255));
      ch = (i < 5) && ($urandom_range(0, 1) == 1);
      check_frame(b, 0, ch, nb, 0);
      if (i == 5) break;
      if (!ch) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        send_byte(nb);
      end
      b = nb;
    end
  endtask
`else
  task automatic test_fifo_order();
    logic [7:0] bytes [4];
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    @(negedge clk);
    for (int k = 0; k <= 4 * FRAME_CYC; k++) begin
      if (k > 0) begin
        n_total++;
        if (tx !== line_bit(bytes[(k-1)/FRAME_CYC], (k-1) % FRAME_CYC + 1))
          $display("FAIL fifo_tx k=%0d got=%b exp=%b", k, tx,
                   line_bit(bytes[(k-1)/FRAME_CYC], (k-1) % FRAME_CYC + 1));
        else n_pass++;
        n_total++;
        if (busy !== (k != 4 * FRAME_CYC))
          $display("FAIL fifo_busy k=%0d got=%b exp=%b", k, busy, (k != 4 * FRAME_CYC));
        else n_pass++;
      end
      if (k < 4) begin
        n_total++;
        if (ready !== 1'b1) $display("FAIL fifo_ready k=%0d got=%b exp=1", k, ready); else n_pass++;
        data  = bytes[k];
        valid = 1'b1;
        exp_q.push_back(bytes[k]);
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] b;
    @(negedge clk);
    b = 8'($urandom_range(0, 255));
    data  = b;
    valid = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      n_total++;
      if (ready !== (i < 16)) $display("FAIL fill_ready i=%0d got=%b exp=%b", i, ready, (i < 16));
      else n_pass++;
      b = 8'($urandom_range(0, 255));
      data  = b;
      valid = 1'b1;
      if (i < 16) exp_q.push_back(b);
      @(negedge clk);
    end
    valid = 1'b0;
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #6_000_000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence and report ----------------
  initial begin
    int w;
    test_reset();
`ifdef EMITTER_UART_FIFO_EN
    test_fifo_order();
    test_fifo_full();
`else
    test_basic();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midframe();
    test_random();
`endif
    w = 0;
    while ((exp_q.size() != 0 || mon_active) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_total++;
    if (exp_q.size() != 0 || mon_active)
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
